// File: rtl/control_unit_n.sv
// Multi-cycle control unit: latches an instruction on Run and sequences one-hot
// register enables and ALU strobes through IDLE/T1/T2/T3/ERR.
module control_unit_n #(
  parameter int NREG  = 4,
  parameter int REG_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2*REG_W+2:0]   INSTRUCTION,
  input  logic                 Run,
  output logic [NREG-1:0]      Rin,
  output logic [NREG-1:0]      Rout,
  output logic                 ALU_a_in,
  output logic                 ALU_g_in,
  output logic                 ALU_g_out,
  output logic                 External_load,
  output logic [2:0]           ALU_mode,
  output logic                 Done,
  output logic                 Error,
  output logic                 Busy
);

  localparam int IW = 3 + 2*REG_W;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [2:0] {IDLE, T1, T2, T3, ERR} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic [2:0]      op;
  logic [REG_W-1:0] rx, ry;
  logic            last;

  assign op = instr_q[IW-1 -: 3];
  assign rx = instr_q[2*REG_W-1 -: REG_W];
  assign ry = instr_q[REG_W-1:0];

  function automatic logic reg_ok(input logic [REG_W-1:0] k);
    return (k != '0) && (int'(k) <= NREG);
  endfunction

  // Field value k drives enable bit k-1; invalid values give an all-zero bus.
  function automatic logic [NREG-1:0] sel(input logic [REG_W-1:0] k);
    logic [NREG-1:0] s;
    s = '0;
    for (int i = 0; i < NREG; i++) s[i] = (int'(k) == i + 1);
    return s;
  endfunction

  function automatic logic instr_ok(input logic [IW-1:0] ins);
    logic [2:0] o;
    o = ins[IW-1 -: 3];
    return (o != OP_RSVD) && reg_ok(ins[2*REG_W-1 -: REG_W]) &&
           ((o == OP_LOAD) || reg_ok(ins[REG_W-1:0]));
  endfunction

  // Cycles in which a new Run may be accepted without a bubble.
  assign last = ((state_q == T1) && (op == OP_LOAD || op == OP_MOV)) ||
                (state_q == T3) || (state_q == ERR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    if (state_q == IDLE || last) begin
      state_d = IDLE;
      if (Run) begin
        instr_d = INSTRUCTION;
        state_d = instr_ok(INSTRUCTION) ? T1 : ERR;
      end
    end else if (state_q == T1) begin
      state_d = T2;
    end else if (state_q == T2) begin
      state_d = T3;
    end
  end

  always_comb begin
    Rin           = '0;
    Rout          = '0;
    ALU_a_in      = 1'b0;
    ALU_g_in      = 1'b0;
    ALU_g_out     = 1'b0;
    External_load = 1'b0;
    ALU_mode      = 3'b000;
    Done          = 1'b0;
    Error         = 1'b0;
    Busy          = (state_q != IDLE);
    case (state_q)
      T1: begin
        if (op == OP_LOAD) begin
          External_load = 1'b1;
          Rin           = sel(rx);
          Done          = 1'b1;
        end else if (op == OP_MOV) begin
          Rout = sel(ry);
          Rin  = sel(rx);
          Done = 1'b1;
        end else begin
          Rout     = sel(rx);
          ALU_a_in = 1'b1;
        end
      end
      T2: begin
        Rout     = sel(ry);
        ALU_g_in = 1'b1;
        ALU_mode = op;
      end
      T3: begin
        ALU_g_out = 1'b1;
        Rin       = sel(rx);
        Done      = 1'b1;
      end
      ERR:     Error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit_n.sv
// Directed bench for control_unit_n: expected output vectors are queued when an
// instruction is issued and compared cycle by cycle as the unit executes it.
module tb_control_unit_n;

  localparam int NREG  = 4;
  localparam int REG_W = 4;
  localparam int IW    = 3 + 2*REG_W;

  logic            clk;
  logic            reset;
  logic [IW-1:0]   INSTRUCTION;
  logic            Run;
  logic [NREG-1:0] Rin, Rout;
  logic            ALU_a_in, ALU_g_in, ALU_g_out, External_load;
  logic [2:0]      ALU_mode;
  logic            Done, Error, Busy;

  control_unit_n #(.NREG(NREG), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset), .INSTRUCTION(INSTRUCTION), .Run(Run),
    .Rin(Rin), .Rout(Rout), .ALU_a_in(ALU_a_in), .ALU_g_in(ALU_g_in),
    .ALU_g_out(ALU_g_out), .External_load(External_load), .ALU_mode(ALU_mode),
    .Done(Done), .Error(Error), .Busy(Busy)
  );

  typedef struct packed {
    logic [NREG-1:0] rin;
    logic [NREG-1:0] rout;
    logic            a_in;
    logic            g_in;
    logic            g_out;
    logic            ext;
    logic [2:0]      mode;
    logic            done;
    logic            err;
    logic            busy;
  } obs_t;

  obs_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t observed();
    obs_t o;
    o.rin = Rin; o.rout = Rout; o.a_in = ALU_a_in; o.g_in = ALU_g_in;
    o.g_out = ALU_g_out; o.ext = External_load; o.mode = ALU_mode;
    o.done = Done; o.err = Error; o.busy = Busy;
    return o;
  endfunction

  function automatic logic [NREG-1:0] bit_of(input int k);
    logic [NREG-1:0] one;
    one = 1;
    return one << (k - 1);
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: expected per-cycle outputs for one accepted instruction.
  task automatic expect_instr(input logic [IW-1:0] ins);
    int   op, rx, ry;
    bit   rx_ok, ry_ok;
    obs_t v;
    op = int'(ins[10:8]);
    rx = int'(ins[7:4]);
    ry = int'(ins[3:0]);
    rx_ok = (rx >= 1) && (rx <= NREG);
    ry_ok = (ry >= 1) && (ry <= NREG);
    if (op == 7 || !rx_ok || (op != 0 && !ry_ok)) begin
      v = '0; v.err = 1'b1; v.busy = 1'b1; sb.push_back(v);
    end else if (op == 0) begin
      v = '0; v.ext = 1'b1; v.rin = bit_of(rx); v.done = 1'b1; v.busy = 1'b1;
      sb.push_back(v);
    end else if (op == 1) begin
      v = '0; v.rout = bit_of(ry); v.rin = bit_of(rx); v.done = 1'b1; v.busy = 1'b1;
      sb.push_back(v);
    end else begin
      v = '0; v.rout = bit_of(rx); v.a_in = 1'b1; v.busy = 1'b1; sb.push_back(v);
      v = '0; v.rout = bit_of(ry); v.g_in = 1'b1; v.mode = 3'(op); v.busy = 1'b1;
      sb.push_back(v);
      v = '0; v.g_out = 1'b1; v.rin = bit_of(rx); v.done = 1'b1; v.busy = 1'b1;
      sb.push_back(v);
    end
  endtask

  task automatic issue(input logic [IW-1:0] ins);
    INSTRUCTION = ins;
    Run = 1'b1;
    expect_instr(ins);
  endtask

  // Advance one clock and compare at the falling edge; empty queue means idle.
  task automatic step(input string tag);
    obs_t e;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '0;
    check(tag, observed(), e);
  endtask

  initial begin
    reset = 1'b0;
    Run = 1'b0;
    INSTRUCTION = '0;
    #1 check("reset_state", observed(), obs_t'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("release_no_change", observed(), obs_t'(0));
    step("idle_after_release");

    // load R1 <- imm 6, then idle
    issue(11'b000_0001_0110);
    step("load_t1");
    Run = 1'b0;
    step("load_after");

    // mov R1 <- R2
    issue(11'b001_0001_0010);
    step("mov_t1");
    Run = 1'b0;
    step("mov_after");

    // add R3, R4 with INSTRUCTION scrambled mid-op
    issue(11'b010_0011_0100);
    step("add_t1");
    Run = 1'b0;
    INSTRUCTION = 11'b111_1111_1111;
    step("add_t2");
    INSTRUCTION = 11'b001_0010_0001;
    step("add_t3");
    step("add_after");

    // invalid Rx = 5
    issue(11'b101_0101_0101);
    step("err_rx");
    Run = 1'b0;
    step("err_after");

    // mov with Ry = 0, reserved opcode, load with Rx = 0
    issue(11'b001_0010_0000);
    step("err_ry0");
    Run = 1'b0;
    step("err_ry0_after");
    issue(11'b111_0001_0001);
    step("err_rsvd");
    Run = 1'b0;
    step("err_rsvd_after");
    issue(11'b000_0000_0011);
    step("err_load_rx0");
    Run = 1'b0;
    step("err_load_rx0_after");

    // load immediate field is not range-checked; Rx = NREG is valid
    issue(11'b000_0100_1111);
    step("load_imm_unchecked");
    Run = 1'b0;
    step("load_imm_after");

    // and / or / xor
    issue(11'b100_0100_0001);
    step("and_t1");
    Run = 1'b0;
    step("and_t2");
    step("and_t3");
    issue(11'b101_0010_0011);
    step("or_t1");
    Run = 1'b0;
    step("or_t2");
    step("or_t3");
    issue(11'b110_0001_0100);
    step("xor_t1");
    Run = 1'b0;
    step("xor_t2");
    step("xor_t3");
    step("xor_after");

    // Run held through an ALU op: ignored in T1/T2, accepted in T3
    issue(11'b011_0010_0001);
    step("sub_t1");
    issue(11'b001_0100_0011);
    step("sub_t2_run_ignored");
    step("sub_t3");
    step("mov_chained");
    Run = 1'b0;
    step("chain_after");

    // back-to-back mov then load, Busy held
    issue(11'b001_0011_0001);
    step("b2b_mov");
    issue(11'b000_0010_0111);
    step("b2b_load");
    Run = 1'b0;
    step("b2b_after");

    // error followed directly by a valid instruction
    issue(11'b111_0000_0000);
    step("b2b_err");
    issue(11'b001_0001_0100);
    step("b2b_err_then_mov");
    Run = 1'b0;
    step("b2b_err_after");

    // asynchronous reset in T2 of sub, then a mov after release
    issue(11'b011_0010_0100);
    step("rst_sub_t1");
    Run = 1'b0;
    step("rst_sub_t2");
    #2 reset = 1'b0;
    #1 check("async_reset_clears", observed(), obs_t'(0));
    sb.delete();
    step("reset_held");
    reset = 1'b1;
    check("release_holds_idle", observed(), obs_t'(0));
    step("idle_after_rst");
    issue(11'b001_0001_0011);
    step("mov_after_rst");
    Run = 1'b0;
    step("mov_after_rst_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
